// File: rtl/jk_ff_bank.sv
// rtl/jk_ff_bank.sv - WIDTH-bit JK/D/T/shift flip-flop bank with change flag and saturating transition counter
// Q, changed and toggles all update on the same rising edge; reset is asynchronous, active-low.
module jk_ff_bank #(
   parameter int               WIDTH     = 4,
   parameter int               CNT_W     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] J,
   input  logic [WIDTH-1:0] K,
   input  logic             sin,
   input  logic             toggles_clr,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qn,
   output logic             changed,
   output logic [CNT_W-1:0] toggles
);

   localparam int             SW      = CNT_W + 1;
   localparam logic [SW-1:0]  CNT_MAX = {1'b0, {CNT_W{1'b1}}};

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] shifted;
   logic [SW-1:0]    delta;
   logic [SW-1:0]    sum;
   logic [CNT_W-1:0] cnt_r;
   logic             chg_r;

   // A one-bit bank has no lower bits to shift up; it just loads sin.
   generate
      if (WIDTH == 1) begin : g_shift1
         assign shifted = sin;
      end else begin : g_shiftn
         assign shifted = {q_r[WIDTH-2:0], sin};
      end
   endgenerate

   always_comb begin
      q_next = q_r;
      if (enable) begin
         case (mode)
            2'b00:   q_next = (J & ~q_r) | (~K & q_r);
            2'b01:   q_next = J;
            2'b10:   q_next = q_r ^ J;
            default: q_next = shifted;
         endcase
      end
      // q_next equals q_r when disabled, so delta is naturally zero then.
      delta = '0;
      for (int i = 0; i < WIDTH; i++) begin
         delta = delta + SW'(q_next[i] ^ q_r[i]);
      end
      sum = {1'b0, cnt_r} + delta;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_r   <= RESET_VAL;
         chg_r <= 1'b0;
         cnt_r <= '0;
      end else begin
         q_r   <= q_next;
         chg_r <= (q_next != q_r);
         if (toggles_clr) begin
            cnt_r <= '0;
         end else if (sum > CNT_MAX) begin
            cnt_r <= '1;
         end else begin
            cnt_r <= sum[CNT_W-1:0];
         end
      end
   end

   assign Q       = q_r;
   assign Qn      = ~q_r;
   assign changed = chg_r;
   assign toggles = cnt_r;

endmodule

// File: tb/tb_jk_ff_bank.sv
// tb/tb_jk_ff_bank.sv - directed self-checking bench for jk_ff_bank (default and 3-bit counter instances)
module tb_jk_ff_bank;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [1:0] mode;
   logic [3:0] J;
   logic [3:0] K;
   logic       sin;
   logic       toggles_clr;

   logic [3:0] q_a, qn_a, q_b, qn_b;
   logic       chg_a, chg_b;
   logic [7:0] tog_a;
   logic [2:0] tog_b;

   int n_vec = 0;
   int n_err = 0;

   jk_ff_bank u_dut (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode), .J(J), .K(K),
      .sin(sin), .toggles_clr(toggles_clr),
      .Q(q_a), .Qn(qn_a), .changed(chg_a), .toggles(tog_a)
   );

   jk_ff_bank #(.WIDTH(4), .CNT_W(3), .RESET_VAL(4'b0000)) u_sat (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode), .J(J), .K(K),
      .sin(sin), .toggles_clr(toggles_clr),
      .Q(q_b), .Qn(qn_b), .changed(chg_b), .toggles(tog_b)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic fresh_start;
      reset = 1'b0; enable = 1'b1; mode = 2'b00; J = '0; K = '0; sin = 1'b0; toggles_clr = 1'b0;
      tick();
      #2 reset = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b0; enable = 1'b1; mode = 2'b00; J = 4'b1111; K = 4'b1111; sin = 1'b1; toggles_clr = 1'b0;
      repeat (3) tick();
      n_vec++;
      if ({q_a, qn_a, chg_a, tog_a} !== {4'b0000, 4'b1111, 1'b0, 8'd0}) begin
         n_err++;
         $display("FAIL reset_state: got q=%b qn=%b chg=%b tog=%0d want q=0000 qn=1111 chg=0 tog=0", q_a, qn_a, chg_a, tog_a);
      end
      #2 reset = 1'b1; J = '0; K = '0;
      #1;
      n_vec++;
      if (q_a !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_release_no_edge: got q=%b want 0000", q_a);
      end
   endtask

   task automatic test_jk;
      mode = 2'b00; J = 4'b1010; K = 4'b0110;
      tick();
      n_vec++;
      if ({q_a, chg_a, tog_a} !== {4'b1010, 1'b1, 8'd2}) begin
         n_err++;
         $display("FAIL jk_edge: got q=%b chg=%b tog=%0d want q=1010 chg=1 tog=2", q_a, chg_a, tog_a);
      end
      J = 4'b0000; K = 4'b0000;
      tick();
      n_vec++;
      if ({q_a, chg_a, tog_a} !== {4'b1010, 1'b0, 8'd2}) begin
         n_err++;
         $display("FAIL jk_hold: got q=%b chg=%b tog=%0d want q=1010 chg=0 tog=2", q_a, chg_a, tog_a);
      end
   endtask

   task automatic test_t_and_d;
      fresh_start();
      mode = 2'b10; J = 4'b0101;
      tick();
      n_vec++;
      if ({q_a, chg_a, tog_a} !== {4'b0101, 1'b1, 8'd2}) begin
         n_err++;
         $display("FAIL t_first: got q=%b chg=%b tog=%0d want q=0101 chg=1 tog=2", q_a, chg_a, tog_a);
      end
      J = 4'b1111;
      tick();
      n_vec++;
      if ({q_a, qn_a, tog_a} !== {4'b1010, 4'b0101, 8'd6}) begin
         n_err++;
         $display("FAIL t_all: got q=%b qn=%b tog=%0d want q=1010 qn=0101 tog=6", q_a, qn_a, tog_a);
      end
      mode = 2'b01; J = 4'b0011; K = 4'b1111;
      tick();
      n_vec++;
      if ({q_a, chg_a, tog_a} !== {4'b0011, 1'b1, 8'd8}) begin
         n_err++;
         $display("FAIL d_load: got q=%b chg=%b tog=%0d want q=0011 chg=1 tog=8", q_a, chg_a, tog_a);
      end
      tick();
      n_vec++;
      if ({q_a, chg_a, tog_a} !== {4'b0011, 1'b0, 8'd8}) begin
         n_err++;
         $display("FAIL d_same: got q=%b chg=%b tog=%0d want q=0011 chg=0 tog=8", q_a, chg_a, tog_a);
      end
   endtask

   task automatic test_shift_hold;
      logic [3:0] exp_q [4];
      exp_q[0] = 4'b0001; exp_q[1] = 4'b0011; exp_q[2] = 4'b0111; exp_q[3] = 4'b1111;
      fresh_start();
      mode = 2'b11; sin = 1'b1; K = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_vec++;
         if (q_a !== exp_q[i]) begin
            n_err++;
            $display("FAIL shift_step%0d: got q=%b want %b", i, q_a, exp_q[i]);
         end
      end
      enable = 1'b0; sin = 1'b0;
      repeat (2) tick();
      n_vec++;
      if ({q_a, chg_a, tog_a} !== {4'b1111, 1'b0, 8'd4}) begin
         n_err++;
         $display("FAIL hold: got q=%b chg=%b tog=%0d want q=1111 chg=0 tog=4", q_a, chg_a, tog_a);
      end
      toggles_clr = 1'b1;
      tick();
      toggles_clr = 1'b0; enable = 1'b1;
      n_vec++;
      if ({q_a, tog_a} !== {4'b1111, 8'd0}) begin
         n_err++;
         $display("FAIL clr_while_disabled: got q=%b tog=%0d want q=1111 tog=0", q_a, tog_a);
      end
   endtask

   task automatic test_saturate_clear;
      fresh_start();
      mode = 2'b10; J = 4'b1111;
      tick();
      n_vec++;
      if ({q_b, tog_b} !== {4'b1111, 3'd4}) begin
         n_err++;
         $display("FAIL sat_edge1: got q=%b tog=%0d want q=1111 tog=4", q_b, tog_b);
      end
      tick();
      n_vec++;
      if ({q_b, tog_b, tog_a} !== {4'b0000, 3'd7, 8'd8}) begin
         n_err++;
         $display("FAIL sat_edge2: got q=%b tog3=%0d tog8=%0d want q=0000 tog3=7 tog8=8", q_b, tog_b, tog_a);
      end
      tick();
      n_vec++;
      if ({tog_b, tog_a} !== {3'd7, 8'd12}) begin
         n_err++;
         $display("FAIL sat_edge3: got tog3=%0d tog8=%0d want tog3=7 tog8=12", tog_b, tog_a);
      end
      toggles_clr = 1'b1;
      tick();
      toggles_clr = 1'b0;
      n_vec++;
      if ({q_b, chg_b, tog_b, tog_a} !== {4'b0000, 1'b1, 3'd0, 8'd0}) begin
         n_err++;
         $display("FAIL clr_priority: got q=%b chg=%b tog3=%0d tog8=%0d want q=0000 chg=1 tog3=0 tog8=0", q_b, chg_b, tog_b, tog_a);
      end
      tick();
      n_vec++;
      if ({q_b, tog_b} !== {4'b1111, 3'd4}) begin
         n_err++;
         $display("FAIL after_clr: got q=%b tog=%0d want q=1111 tog=4", q_b, tog_b);
      end
   endtask

   task automatic test_async_reset;
      fresh_start();
      mode = 2'b11; sin = 1'b1;
      repeat (3) tick();
      n_vec++;
      if ({q_a, tog_a} !== {4'b0111, 8'd3}) begin
         n_err++;
         $display("FAIL pre_reset: got q=%b tog=%0d want q=0111 tog=3", q_a, tog_a);
      end
      #2 reset = 1'b0;
      #1;
      n_vec++;
      if ({q_a, qn_a, chg_a, tog_a} !== {4'b0000, 4'b1111, 1'b0, 8'd0}) begin
         n_err++;
         $display("FAIL async_reset: got q=%b qn=%b chg=%b tog=%0d want q=0000 qn=1111 chg=0 tog=0", q_a, qn_a, chg_a, tog_a);
      end
      #1 reset = 1'b1;
      tick();
      n_vec++;
      if ({q_a, chg_a, tog_a} !== {4'b0001, 1'b1, 8'd1}) begin
         n_err++;
         $display("FAIL resume_shift: got q=%b chg=%b tog=%0d want q=0001 chg=1 tog=1", q_a, chg_a, tog_a);
      end
   endtask

   initial begin
      test_reset();
      test_jk();
      test_t_and_d();
      test_shift_hold();
      test_saturate_clear();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
